mul_div_unit: RTL and testbench
===============================

// Module: mul_div_unit
// PURPOSE
//  Iterative multiply/divide unit beside the ALU in EX. Takes the same A/B operands and implements
//  MULT, MULTU, DIV and DIVU. Results go into architectural HI/LO registers, which MFHI/MFLO read.
//  The start/busy/done handshake lets hazard control stall a pipeline that touches HI/LO while busy.
// PARAMETERS
//  WIDTH   32   operand/result width; iteration count equals WIDTH
// PORTS
//  clk      in   1      clock, rising edge
//  rst_n    in   1      asynchronous, active-low reset
//  start    in   1      launch op; sampled only when not busy
//  op       in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  A        in   WIDTH  rs operand (multiplicand / dividend)
//  B        in   WIDTH  rt operand (multiplier / divisor)
//  hi_we    in   1      MTHI write strobe
//  lo_we    in   1      MTLO write strobe
//  wdata    in   WIDTH  MTHI/MTLO data
//  busy     out  1      operation in flight
//  done     out  1      one-cycle pulse; HI/LO hold the new result
//  hi       out  WIDTH  HI register (product high / remainder)
//  lo       out  WIDTH  LO register (product low / quotient)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, busy=0, done=0, hi=0, lo=0, all internal regs=0.
//  FSM: IDLE -> CALC -> FIX -> DONE -> IDLE (or straight back to CALC on a new start).
//  - IDLE/DONE: on start=1, latch op. Signed ops latch |A| and |B| plus sign bits;
//    unsigned ops latch raw values. Clear the counter, go to CALC.
//  - CALC: one radix-2 step per cycle for exactly WIDTH cycles, then go to FIX.
//    Multiply uses shift-add into a 2*WIDTH accumulator.
//    Divide uses restoring shift-subtract.
//  - FIX: sign-correct the result and write hi/lo, then go to DONE.
//    Signed multiply: negate the 64-bit product if sign(A)^sign(B).
//    Signed divide: quotient takes sign(A)^sign(B); remainder takes sign(A).
//  - DONE: done=1 for exactly this cycle.
//  Latency: start sampled at edge 0 -> done=1 in the cycle after edge WIDTH+1 (cycle 34 for 32).
//  busy=1 from the cycle after edge 0 through FIX. busy=0 in IDLE and DONE.
//  start while busy: ignored, with no effect on the current op.
//  hi_we/lo_we: write wdata at the edge, only when busy=0.
//  - While busy they are ignored.
//  - Both together write both registers.
//  - hi_we with start in the same cycle: the write lands, and the op result overwrites it at FIX.
//  Width/arithmetic: all internal math is modulo 2^WIDTH per half.
//  - DIV 0x80000000 / -1: lo=0x80000000, hi=0 (wraps, no trap).
//  Divide by zero (any signedness): full latency kept; at FIX lo=all ones, hi=A (original,
//    unmodified); no sign correction.
//  Reset mid-operation: aborts immediately to the reset values above.
//  op/A/B may change after the start cycle without effect.
// STRUCTURE
//  Package mdu_pkg:
//  - localparams OP_MULT=2'b00, OP_MULTU=2'b01, OP_DIV=2'b10, OP_DIVU=2'b11
//  - state encoding IDLE/CALC/FIX/DONE
//  - counter width $clog2(WIDTH)+1
//  Sub-module mdu_abs_neg (combinational, parameter WIDTH):
//  - inputs: value, negate enable; output: two's-complement negate-if-enabled
//  - used for operand magnitude and result sign fix
//  FSM and datapath registers stay in mul_div_unit.
// TESTING
//  1 MULTU A=FFFFFFFF B=FFFFFFFF -> done at cycle 34; hi=FFFFFFFE lo=00000001; busy low during done
//  2 MULT A=FFFFFFFD(-3) B=00000007 -> hi=FFFFFFFF lo=FFFFFFEB; then DIVU 7/2 -> lo=3 hi=1
//  3 DIV A=FFFFFFF9(-7) B=2 -> lo=FFFFFFFD hi=FFFFFFFF; DIV 80000000/FFFFFFFF -> lo=80000000 hi=0
//  4 DIVU 5/0 -> lo=FFFFFFFF hi=00000005, done still at cycle 34; DIV FFFFFFF9/0 -> hi=FFFFFFF9
//  5 start during busy, and hi_we=1 wdata=1234 at cycle 10 -> both ignored, original result intact;
//    hi_we in IDLE -> hi=1234 next cycle, lo unchanged
//  6 rst_n low at cycle 10 of a MULT -> busy=0 done=0 hi=lo=0 async; new start after release gives correct result

Source files
------------

// File: rtl/mdu_pkg.sv
// ============================================================================
// Module : mdu_pkg
// Brief  : Shared opcodes, FSM state encoding and sizing helper for the MDU.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mdu_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_t;

    // Counter must be able to hold WIDTH-1 with headroom for the compare
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_abs_neg.sv
// ============================================================================
// Module : mdu_abs_neg
// Brief  : Two's-complement conditional negate (magnitude / sign restore).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mdu_abs_neg #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_value,
    input  logic             i_negate,
    output logic [WIDTH-1:0] o_result
);

    assign o_result = i_negate ? (~i_value + WIDTH'(1)) : i_value;

endmodule

`default_nettype wire

// File: rtl/mul_div_unit.sv
// ============================================================================
// Module : mul_div_unit
// Brief  : Iterative radix-2 MULT/MULTU/DIV/DIVU unit owning HI/LO.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    import mdu_pkg::*;

    localparam int CNT_W = cnt_width(WIDTH);

    mdu_state_t         r_state;
    logic               r_is_mul;
    logic               r_sign_a;
    logic               r_sign_b;
    logic               r_div0;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_a_raw;
    logic [2*WIDTH-1:0] r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_in_signed;
    logic               w_neg_a_in;
    logic               w_neg_b_in;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH:0]     w_div_diff;
    logic               w_div_ok;
    logic [2*WIDTH-1:0] w_div_next;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    // MULT and DIV have op[0]=0; only those take operand magnitudes
    assign w_in_signed = ~op[0];
    assign w_neg_a_in  = w_in_signed & A[WIDTH-1];
    assign w_neg_b_in  = w_in_signed & B[WIDTH-1];

    mdu_abs_neg #(.WIDTH(WIDTH)) u_abs_a (
        .i_value  (A),
        .i_negate (w_neg_a_in),
        .o_result (w_abs_a)
    );

    mdu_abs_neg #(.WIDTH(WIDTH)) u_abs_b (
        .i_value  (B),
        .i_negate (w_neg_b_in),
        .o_result (w_abs_b)
    );

    // Shift-add: low half holds the remaining multiplier bits
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Restoring divide: high half is the partial remainder, low half the quotient
    assign w_div_shift = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_div_diff  = w_div_shift - {1'b0, r_b};
    assign w_div_ok    = ~w_div_diff[WIDTH];
    assign w_div_next  = {(w_div_ok ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0]),
                          r_acc[WIDTH-2:0], w_div_ok};

    // Sign bits are zero for unsigned ops, so these are pass-through there
    mdu_abs_neg #(.WIDTH(2*WIDTH)) u_fix_prod (
        .i_value  (r_acc),
        .i_negate (r_sign_a ^ r_sign_b),
        .o_result (w_prod_fix)
    );

    mdu_abs_neg #(.WIDTH(WIDTH)) u_fix_quo (
        .i_value  (r_acc[WIDTH-1:0]),
        .i_negate (r_sign_a ^ r_sign_b),
        .o_result (w_quo_fix)
    );

    mdu_abs_neg #(.WIDTH(WIDTH)) u_fix_rem (
        .i_value  (r_acc[2*WIDTH-1:WIDTH]),
        .i_negate (r_sign_a),
        .o_result (w_rem_fix)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_is_mul <= 1'b0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_div0   <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_a_raw  <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_done <= 1'b0;
                    if (hi_we) r_hi <= wdata;
                    if (lo_we) r_lo <= wdata;
                    if (start) begin
                        r_is_mul <= ~op[1];
                        r_sign_a <= w_neg_a_in;
                        r_sign_b <= w_neg_b_in;
                        r_div0   <= (B == '0);
                        r_a      <= w_abs_a;
                        r_b      <= w_abs_b;
                        r_a_raw  <= A;
                        r_acc    <= {{WIDTH{1'b0}}, (op[1] ? w_abs_a : w_abs_b)};
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_CALC;
                    end else begin
                        r_state  <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    r_acc <= r_is_mul ? w_mul_next : w_div_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH - 1)) r_state <= ST_FIX;
                end
                ST_FIX: begin
                    if (r_is_mul) begin
                        {r_hi, r_lo} <= w_prod_fix;
                    end else if (r_div0) begin
                        r_hi <= r_a_raw;
                        r_lo <= '1;
                    end else begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= ST_DONE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
// ============================================================================
// Module : tb_mul_div_unit
// Brief  : Scoreboard bench for mul_div_unit against an arithmetic reference.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mul_div_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: plain 64-bit arithmetic, C-style truncating division
    task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] rhi, output logic [31:0] rlo);
        longint      sa;
        longint      sb_;
        longint      q;
        longint      r;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        case (o)
            2'b00: p = 64'(sa * sb_);
            2'b01: p = {32'd0, a} * {32'd0, b};
            default: begin
                if (b == 32'd0) begin
                    p = {a, 32'hFFFF_FFFF};
                end else begin
                    if (o == 2'b10) begin
                        q = sa / sb_;
                        r = sa % sb_;
                    end else begin
                        q = longint'({32'd0, a}) / longint'({32'd0, b});
                        r = longint'({32'd0, a}) % longint'({32'd0, b});
                    end
                    p = {r[31:0], q[31:0]};
                end
            end
        endcase
        rhi = p[63:32];
        rlo = p[31:0];
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("result_hi", {32'd0, hi}, {32'd0, e.hi});
                check("result_lo", {32'd0, lo}, {32'd0, e.lo});
                check("done_cycle", 64'(cyc), 64'(e.cyc));
                check("busy_at_done", {63'd0, busy}, 64'd0);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", 64'd1, 64'd0);
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        wait_idle();
        op    = o;
        A     = a;
        B     = b;
        start = 1'b1;
        model(o, a, b, e.hi, e.lo);
        e.cyc  = cyc + 34;
        exp_hi = e.hi;
        exp_lo = e.lo;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        op    = 2'($urandom);
        A     = $urandom;
        B     = $urandom;
    endtask

    initial begin
        logic [31:0] save_hi;
        logic [31:0] ra;
        logic [31:0] rb;
        int          sel;

        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        A     = '0;
        B     = '0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(2'b00, 32'hFFFF_FFFD, 32'h0000_0007);
        issue(2'b11, 32'd7, 32'd2);
        issue(2'b10, 32'hFFFF_FFF9, 32'd2);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(2'b11, 32'd5, 32'd0);
        issue(2'b10, 32'hFFFF_FFF9, 32'd0);
        issue(2'b10, 32'd7, 32'hFFFF_FFFE);
        issue(2'b00, 32'h8000_0000, 32'h8000_0000);
        wait_idle();

        // Start and MTHI while busy must both be ignored
        save_hi = exp_hi;
        issue(2'b00, 32'h0001_2345, 32'hFFFF_0003);
        repeat (9) @(negedge clk);
        start = 1'b1;
        op    = 2'b11;
        A     = 32'd100;
        B     = 32'd3;
        hi_we = 1'b1;
        wdata = 32'h0000_1234;
        @(negedge clk);
        start = 1'b0;
        hi_we = 1'b0;
        check("busy_write_ignored", {32'd0, hi}, {32'd0, save_hi});
        wait_idle();
        repeat (2) @(negedge clk);

        // MTHI / MTLO while idle
        hi_we = 1'b1;
        wdata = 32'h0000_1234;
        @(negedge clk);
        hi_we = 1'b0;
        check("mthi_hi", {32'd0, hi}, 64'h1234);
        check("mthi_lo_kept", {32'd0, lo}, {32'd0, exp_lo});
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'hCAFE_F00D;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b0;
        check("mthi_mtlo_both", {hi, lo}, 64'hCAFE_F00D_CAFE_F00D);

        // Async reset in the middle of a multiply
        issue(2'b00, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_busy", {63'd0, busy}, 64'd0);
        check("midreset_done", {63'd0, done}, 64'd0);
        check("midreset_hilo", {hi, lo}, 64'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(2'b00, 32'hFFFF_FFFD, 32'h0000_0007);

        // Randomized ops, many issued back-to-back from DONE
        for (int i = 0; i < 24; i++) begin
            sel = int'($urandom_range(0, 7));
            ra  = (sel == 7) ? 32'h8000_0000 : $urandom;
            case (sel)
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = $urandom_range(1, 15);
                default: rb = $urandom;
            endcase
            issue(2'($urandom), ra, rb);
        end
        wait_idle();
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
